// File: rtl/decoder_scan_if.sv
// Control/status bundle for decoder_scan: the driver (master) supplies the
// mode and select inputs and the decoder (slave) returns the one-hot strobe.
interface decoder_scan_if #(
  parameter int SEL_W   = 4,
  parameter int DWELL_W = 8
);
  localparam int N = 1 << SEL_W;

  logic               i_enable;
  logic               i_mode;
  logic               i_single;
  logic [SEL_W-1:0]   i_in;
  logic [DWELL_W-1:0] i_dwell;
  logic [N-1:0]       o_out;
  logic [SEL_W-1:0]   o_index;
  logic               o_wrap;
  logic               o_busy;

  modport master (
    output i_enable, i_mode, i_single, i_in, i_dwell,
    input  o_out, o_index, o_wrap, o_busy
  );

  modport slave (
    input  i_enable, i_mode, i_single, i_in, i_dwell,
    output o_out, o_index, o_wrap, o_busy
  );
endinterface

// File: rtl/decoder_scan.sv
// Registered binary-to-one-hot decoder with a scan sequencer that walks the
// strobe across all lines, holding each for a latched dwell time.
//
// state     | meaning
// ST_DIRECT | out decodes i_in (gated by enable)
// ST_SCAN   | sequencer walks lines, busy high, pauses while enable low
// ST_DONE   | single pass finished; out low until mode drops
module decoder_scan #(
  parameter int SEL_W   = 4,
  parameter int DWELL_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  decoder_scan_if.slave bus
);
  localparam int N = 1 << SEL_W;
  localparam logic [N-1:0]     ONE  = {{(N-1){1'b0}}, 1'b1};
  localparam logic [SEL_W-1:0] LAST = {SEL_W{1'b1}};

  typedef enum logic [1:0] {
    ST_DIRECT = 2'd0,
    ST_SCAN   = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t             r_state;
  logic [N-1:0]       r_out;
  logic [SEL_W-1:0]   r_index;
  logic               r_wrap;
  logic               r_busy;
  logic [DWELL_W-1:0] r_cnt;
  logic [DWELL_W-1:0] r_dwell;

  logic [N-1:0]       w_direct_out;
  logic [SEL_W-1:0]   w_next_index;
  logic               w_line_done;

  assign w_direct_out = bus.i_enable ? (ONE << bus.i_in) : '0;
  assign w_next_index = r_index + {{(SEL_W-1){1'b0}}, 1'b1};
  assign w_line_done  = (r_cnt == r_dwell);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_DIRECT;
      r_out   <= '0;
      r_index <= '0;
      r_wrap  <= 1'b0;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_dwell <= '0;
    end else begin
      r_wrap <= 1'b0;
      case (r_state)
        ST_DIRECT: begin
          if (bus.i_mode) begin
            r_state <= ST_SCAN;
            r_busy  <= 1'b1;
            r_index <= '0;
            r_cnt   <= '0;
            r_dwell <= bus.i_dwell;
            r_out   <= bus.i_enable ? ONE : '0;
          end else begin
            r_out   <= w_direct_out;
            r_index <= bus.i_in;
          end
        end
        ST_SCAN: begin
          if (!bus.i_mode) begin
            r_state <= ST_DIRECT;
            r_busy  <= 1'b0;
            r_out   <= w_direct_out;
            r_index <= bus.i_in;
          end else if (!bus.i_enable) begin
            // paused: index and count hold so the line resumes where it left off
            r_out <= '0;
          end else if (!w_line_done) begin
            r_cnt <= r_cnt + {{(DWELL_W-1){1'b0}}, 1'b1};
            r_out <= ONE << r_index;
          end else begin
            r_cnt <= '0;
            if (r_index == LAST) begin
              r_wrap <= 1'b1;
              if (bus.i_single) begin
                r_state <= ST_DONE;
                r_busy  <= 1'b0;
                r_out   <= '0;
              end else begin
                r_index <= '0;
                r_out   <= ONE;
              end
            end else begin
              r_index <= w_next_index;
              r_out   <= ONE << w_next_index;
            end
          end
        end
        ST_DONE: begin
          if (!bus.i_mode) begin
            r_state <= ST_DIRECT;
            r_out   <= w_direct_out;
            r_index <= bus.i_in;
          end else begin
            r_out <= '0;
          end
        end
        default: begin
          r_state <= ST_DIRECT;
          r_busy  <= 1'b0;
          r_out   <= '0;
        end
      endcase
    end
  end

  assign bus.o_out   = r_out;
  assign bus.o_index = r_index;
  assign bus.o_wrap  = r_wrap;
  assign bus.o_busy  = r_busy;
endmodule
